// File: rtl/manchester_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// manchester_tx_arbiter_if
//
// Request bus between a set of byte requesters and the Manchester transmit
// arbiter. One valid/ready pair and one byte lane per requester.
//
//   req_valid [NUM_REQ-1:0]   requester i has a byte to send
//   req_data  [NUM_REQ*8-1:0] byte of requester i in bits [8i+7:8i]
//   req_ready [NUM_REQ-1:0]   requester i's byte is accepted this cycle
//
// Modports:
//   master - requester side (drives valid/data, observes ready)
//   slave  - arbiter side   (observes valid/data, drives ready)
// -----------------------------------------------------------------------------
interface manchester_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/manchester_tx_arbiter.sv
// -----------------------------------------------------------------------------
// manchester_tx_arbiter
//
// Round-robin arbiter in front of a single Manchester serial transmitter.
// In IDLE one requester is granted (lowest index at or after the round-robin
// pointer), its byte is captured and sent as a frame:
//   start bit 1, requester ID (clog2(NUM_REQ) bits, MSB first),
//   8 data bits (MSB first).
// Each bit is two half-bits of HALF_BIT_CYCLES clocks: 1 = low,high and
// 0 = high,low. After the frame the line is held low for 4 half-bit times
// (GAP) before the next grant is possible.
//
// Parameters:
//   NUM_REQ         number of requesters (2..8)
//   HALF_BIT_CYCLES clocks per Manchester half-bit (>= 1)
//
// Ports:
//   clk       clock, all state changes on rising edge
//   rst       synchronous active-high reset
//   bus       request bus (slave modport): req_valid / req_data / req_ready
//   tx_out    Manchester serial line (low when idle)
//   tx_busy   high in SEND and GAP
//   grant_id  ID of the requester whose frame is in progress, 0 when idle
// -----------------------------------------------------------------------------
module manchester_tx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int HALF_BIT_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  manchester_tx_arbiter_if.slave     bus,
  output logic                       tx_out,
  output logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W       = $clog2(NUM_REQ);
  localparam int CAND_W     = ID_W + 1;
  localparam int FRAME_BITS = 1 + ID_W + 8;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  // One counter serves both the half-bit timer and the gap timer, so it is
  // sized for the longer of the two (the gap).
  localparam int CNT_W      = $clog2(4 * HALF_BIT_CYCLES);

  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(4 * HALF_BIT_CYCLES - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [ID_W-1:0]   ID_LAST   = ID_W'(NUM_REQ - 1);
  localparam logic [CAND_W-1:0] NUM_REQ_C = CAND_W'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;   // MSB is the bit on the line
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    half_q, half_d;     // 0 = first half, 1 = second
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         grant_q, grant_d;

  // ---------------------------------------------------------------------------
  // Per-requester byte lanes
  // ---------------------------------------------------------------------------
  logic [7:0] data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
    assign data_arr[gi] = bus.req_data[8*gi +: 8];
  end

  // ---------------------------------------------------------------------------
  // Round-robin selection
  // Candidates are visited from the farthest offset down to offset 0, so the
  // last hit is the one closest to the pointer.
  // ---------------------------------------------------------------------------
  logic              any_valid;
  logic [ID_W-1:0]   winner;
  logic [CAND_W-1:0] cand;

  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + CAND_W'(k);
      if (cand >= NUM_REQ_C) begin
        cand = cand - NUM_REQ_C;
      end
      if (bus.req_valid[cand[ID_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[ID_W-1:0];
      end
    end
  end

  // A grant is only offered in IDLE and never while reset is asserted, so a
  // requester cannot hand over a byte that reset would immediately discard.
  logic handshake;
  assign handshake = (state_q == IDLE) && any_valid && !rst;

  logic [NUM_REQ-1:0] ready_c;

  always_comb begin
    ready_c = '0;
    if (handshake) begin
      ready_c[winner] = 1'b1;
    end
  end

  assign bus.req_ready = ready_c;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d   = SEND;
          shift_d   = {1'b1, winner, data_arr[winner]};
          bit_cnt_d = '0;
          half_d    = 1'b0;
          cnt_d     = '0;
          ptr_d     = (winner == ID_LAST) ? '0 : winner + 1'b1;
          grant_d   = winner;
        end
      end

      SEND: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              state_d   = GAP;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          grant_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      half_q    <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // The line is decoded purely from registered state, so it only moves at
  // half-bit boundaries and drops to 0 the cycle after SEND is left.
  // ---------------------------------------------------------------------------
  logic cur_bit;
  assign cur_bit  = shift_q[FRAME_BITS-1];
  assign tx_out   = (state_q == SEND) && (half_q ? cur_bit : !cur_bit);
  assign tx_busy  = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: doc/manchester_tx_arbiter.md
MANCHESTER_TX_ARBITER -- requirements
Module: manchester_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter HALF_BIT_CYCLES, default 4: clocks per Manchester half-bit, legal range >=1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: requester i has a byte to send.
REQ-006 SHALL have port req_data, input, NUM_REQ*8 bits: byte of requester i in bits [8i+7:8i].
REQ-007 SHALL have port req_ready, output, NUM_REQ bits: requester i's byte is accepted this cycle.
REQ-008 SHALL have port tx_out, output, 1 bit: Manchester serial line.
REQ-009 SHALL have port tx_busy, output, 1 bit: high while a frame or inter-frame gap is in progress.
REQ-010 SHALL have port grant_id, output, clog2(NUM_REQ) bits: ID of the requester whose frame is in progress; 0 when idle.

Function
REQ-011 SHALL implement the three states IDLE, SEND and GAP.
REQ-012 SHALL, in IDLE with any req_valid high, select as winner the lowest index at or after the round-robin pointer, wrapping modulo NUM_REQ.
REQ-013 SHALL drive req_ready[winner] high combinationally in that IDLE cycle; all other req_ready bits SHALL be 0; req_ready SHALL be all-0 outside IDLE.
REQ-014 SHALL on handshake (req_valid & req_ready) capture the frame, set pointer = (winner+1) mod NUM_REQ, set grant_id = winner, and enter SEND on the next cycle.
REQ-015 SHALL build the frame as: start bit 1, then the ID as clog2(NUM_REQ) bits MSB-first, then the 8 data bits MSB-first (11 bits when NUM_REQ=4).
REQ-016 SHALL encode each bit as two half-bits: bit 1 = low then high; bit 0 = high then low.
REQ-017 SHALL hold each half-bit on tx_out for exactly HALF_BIT_CYCLES clocks.
REQ-018 SHALL change tx_out only at half-bit boundaries, starting with the first SEND cycle.
REQ-019 SHALL after the last half-bit enter GAP and hold tx_out=0 for 4*HALF_BIT_CYCLES cycles, then return to IDLE.
REQ-020 SHALL hold tx_out=0 in IDLE.
REQ-021 SHALL drive tx_busy=1 exactly in SEND and GAP.
REQ-022 SHALL make frame data immune to req_data or req_valid changes after the handshake.
REQ-023 SHALL ignore req_valid in SEND and GAP, with no queuing; a requester holds valid until it sees ready.
REQ-024 SHALL give no priority to a request that appeared during SEND or GAP; round-robin order alone decides.
REQ-025 SHALL reach IDLE directly from GAP; there are no back-to-back frames without a gap.
REQ-026 SHALL allow a new handshake in the first IDLE cycle after GAP.
REQ-027 SHALL take exactly (2*FRAME_BITS+4)*HALF_BIT_CYCLES cycles from handshake cycle+1 to the next possible handshake.
REQ-028 SHALL wrap all counters within their ranges, with no overflow into other state.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, go next cycle to state IDLE with pointer=0, grant_id=0, tx_out=0, tx_busy=0 and all counters 0.
REQ-030 SHALL keep req_ready=0 during any cycle with rst=1.
REQ-031 SHALL on reset mid-SEND or mid-GAP abort the frame immediately (tx_out=0 next cycle) and not retransmit it.

Verification (NUM_REQ=4, HALF_BIT_CYCLES=2 unless stated)
REQ-032 Reset: rst=1 for 3 cycles with all req_valid=1 -> req_ready=0000, tx_out=0, tx_busy=0; after release, first grant goes to requester 0.
REQ-033 Single frame: req_valid=0100, data[2]=0xA5 -> req_ready=0100 for one cycle; bits 1,1,0,1,0,1,0,0,1,0,1; tx_out starts 0,0,1,1,0,0,1,1,1,1,0,0; tx_busy high 52 cycles; grant_id=2.
REQ-034 Fairness: req_valid=1111 held continuously -> grant order 0,1,2,3,0; handshakes 52 cycles apart.
REQ-035 Skip: pointer=1 after grant 0, req_valid=1001 -> grant 3, then 0.
REQ-036 Reset mid-frame: rst at cycle 10 of SEND -> tx_out=0 and tx_busy=0 next cycle; next grant starts from requester 0.
REQ-037 HALF_BIT_CYCLES=1, data 0x00 from requester 1 -> tx_out 0,1,1,0,0,1, then 8x(1,0), then 4 cycles 0; tx_busy high 26 cycles.
